// File: rtl/wait_seq_pkg.sv
// Shared types for the wait-condition sequencer: compare opcodes, FSM states
// and the per-stage configuration record.
package wait_seq_pkg;

    // Operand width held in the stage table; narrower monitored values are zero-extended.
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        EQ    = 3'd0,
        NE    = 3'd1,
        LT    = 3'd2,
        GT    = 3'd3,
        RANGE = 3'd4,
        NEVER = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2,
        TMO  = 2'd3
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
    } stage_cfg_t;

endpackage

// File: rtl/wait_cond_eval.sv
// Combinational evaluation of one wait condition against the monitored value.
module wait_cond_eval
    import wait_seq_pkg::*;
(
    input  stage_cfg_t        cfg,
    input  logic [DATA_W-1:0] value,
    output logic              match
);

    always_comb begin
        match = 1'b0;
        case (cfg.op)
            EQ:      match = (value == cfg.lo);
            NE:      match = (value != cfg.lo);
            LT:      match = (value <  cfg.lo);
            GT:      match = (value >  cfg.lo);
            RANGE:   match = (value >  cfg.lo) && (value < cfg.hi);
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/wait_seq_ctrl.sv
// Steps a monitored value through a programmed list of wait conditions and
// flags completion, or a per-stage timeout if a stage stalls.
//
// state | meaning
// IDLE  | after reset, table writable, waiting for start
// WAIT  | evaluating table[stage] every cycle, timer counting stall cycles
// DONE  | all active stages satisfied, done held, restartable
// TMO   | a stage exceeded its limit, timeout held, restartable
module wait_seq_ctrl
    import wait_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TO_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_idx,
    input  logic [2:0]               cfg_op,
    input  logic [WIDTH-1:0]         cfg_lo,
    input  logic [WIDTH-1:0]         cfg_hi,
    input  logic [$clog2(DEPTH):0]   n_stages,
    input  logic [TO_W-1:0]          to_limit,
    input  logic                     start,
    input  logic [WIDTH-1:0]         value,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] stage,
    output logic                     hit,
    output logic                     done,
    output logic                     timeout
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    state_e           state;
    stage_cfg_t       tbl [DEPTH];
    logic [CNT_W-1:0] n_lat;
    logic [TO_W-1:0]  to_lat;
    logic [TO_W-1:0]  timer;

    logic             match;
    logic             last;
    logic [CNT_W-1:0] n_in;
    logic [CNT_W-1:0] stage_nx;
    logic [TO_W-1:0]  timer_inc;

    wait_cond_eval u_eval (
        .cfg   (tbl[stage]),
        .value (DATA_W'(value)),
        .match (match)
    );

    // Counts above DEPTH would wrap the stage index, so they are clamped.
    assign n_in      = (n_stages > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : n_stages;
    assign stage_nx  = {1'b0, stage} + CNT_W'(1);
    assign last      = (stage_nx >= n_lat);
    assign timer_inc = (timer == '1) ? timer : timer + TO_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '{op: NEVER, lo: '0, hi: '0};
            end
        end else if (cfg_we && state != WAIT) begin
            tbl[cfg_idx] <= '{op: op_e'(cfg_op), lo: DATA_W'(cfg_lo), hi: DATA_W'(cfg_hi)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            stage   <= '0;
            hit     <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            timer   <= '0;
            n_lat   <= '0;
            to_lat  <= '0;
        end else begin
            hit <= 1'b0;
            case (state)
                WAIT: begin
                    // A match takes priority over an expiring timer.
                    if (match) begin
                        hit   <= 1'b1;
                        timer <= '0;
                        if (last) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            stage <= stage + IDX_W'(1);
                        end
                    end else begin
                        timer <= timer_inc;
                        if (to_lat != '0 && timer_inc == to_lat) begin
                            state   <= TMO;
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        n_lat   <= n_in;
                        to_lat  <= to_limit;
                        stage   <= '0;
                        timer   <= '0;
                        timeout <= 1'b0;
                        if (n_in == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wait_seq_ctrl.sv
// Directed bench for wait_seq_ctrl: expected hit events are queued when the
// value is driven and checked by a monitor whenever hit pulses.
module tb_wait_seq_ctrl;
    import wait_seq_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int TO_W  = 16;
    localparam logic [31:0] MAXV = 32'hFFFF_FFFF;

    logic             clk;
    logic             rst;
    logic             cfg_we;
    logic [1:0]       cfg_idx;
    logic [2:0]       cfg_op;
    logic [WIDTH-1:0] cfg_lo;
    logic [WIDTH-1:0] cfg_hi;
    logic [2:0]       n_stages;
    logic [TO_W-1:0]  to_limit;
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic [1:0]       stage;
    logic             hit;
    logic             done;
    logic             timeout;

    typedef struct {
        logic [1:0] stg;
        logic       chk_stg;
        logic       dn;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] v;
        logic        m;
    } case_t;

    exp_t  sb [$];
    case_t cases [14];
    int    total = 0;
    int    bad   = 0;

    wait_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TO_W(TO_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_op   (cfg_op),
        .cfg_lo   (cfg_lo),
        .cfg_hi   (cfg_hi),
        .n_stages (n_stages),
        .to_limit (to_limit),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .stage    (stage),
        .hit      (hit),
        .done     (done),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Each hit must correspond to the oldest queued expectation.
    always @(negedge clk) begin
        if (hit === 1'b1) begin
            exp_t e;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_hit obs_stage=%0d obs_done=%0b exp=no hit", stage, done);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.chk_stg) begin
                    total++;
                    assert (stage === e.stg) else begin
                        bad++;
                        $error("FAIL hit_stage obs=%0d exp=%0d", stage, e.stg);
                    end
                end
                total++;
                assert (done === e.dn) else begin
                    bad++;
                    $error("FAIL hit_done obs=%0b exp=%0b", done, e.dn);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [2:0] op,
                       input logic [31:0] lo, input logic [31:0] hi);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_op  = op;
        cfg_lo  = lo;
        cfg_hi  = hi;
        step(1);
        cfg_we  = 1'b0;
    endtask

    task automatic go(input logic [2:0] n, input logic [TO_W-1:0] tl);
        n_stages = n;
        to_limit = tl;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
    endtask

    task automatic push(input logic [1:0] stg, input logic chk_stg, input logic dn);
        sb.push_back('{stg: stg, chk_stg: chk_stg, dn: dn});
    endtask

    initial begin
        cases[0]  = '{op: EQ,    lo: 0,    hi: 0,    v: 0,    m: 1'b1};
        cases[1]  = '{op: EQ,    lo: MAXV, hi: 0,    v: MAXV, m: 1'b1};
        cases[2]  = '{op: EQ,    lo: 0,    hi: 0,    v: MAXV, m: 1'b0};
        cases[3]  = '{op: NE,    lo: 0,    hi: 0,    v: MAXV, m: 1'b1};
        cases[4]  = '{op: NE,    lo: MAXV, hi: 0,    v: MAXV, m: 1'b0};
        cases[5]  = '{op: LT,    lo: 0,    hi: 0,    v: 0,    m: 1'b0};
        cases[6]  = '{op: LT,    lo: MAXV, hi: 0,    v: 0,    m: 1'b1};
        cases[7]  = '{op: LT,    lo: MAXV, hi: 0,    v: MAXV, m: 1'b0};
        cases[8]  = '{op: GT,    lo: MAXV, hi: 0,    v: MAXV, m: 1'b0};
        cases[9]  = '{op: GT,    lo: 0,    hi: 0,    v: MAXV, m: 1'b1};
        cases[10] = '{op: GT,    lo: 0,    hi: 0,    v: 0,    m: 1'b0};
        cases[11] = '{op: 3'd5,  lo: 0,    hi: 0,    v: 0,    m: 1'b0};
        cases[12] = '{op: RANGE, lo: 0,    hi: MAXV, v: 1,    m: 1'b1};
        cases[13] = '{op: RANGE, lo: 0,    hi: MAXV, v: MAXV, m: 1'b0};

        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_op = '0; cfg_lo = '0; cfg_hi = '0;
        n_stages = '0; to_limit = '0; start = 1'b0; value = '0;
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stage", 32'(stage), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout", 32'(timeout), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1);

        // Main sequence: EQ 2, LT 2, EQ 0, RANGE(1,3)
        cfg(0, EQ, 2, 0);
        cfg(1, LT, 2, 0);
        cfg(2, EQ, 0, 0);
        cfg(3, RANGE, 1, 3);
        value = 0;
        go(4, 0);
        chk("seq_busy", 32'(busy), 1);
        chk("seq_stage0", 32'(stage), 0);
        chk("seq_done0", 32'(done), 0);
        step(2);
        value = 1;
        step(2);
        chk("seq_stage_hold", 32'(stage), 0);
        push(1, 1'b1, 1'b0);
        value = 2;
        step(2);
        push(2, 1'b1, 1'b0);
        push(3, 1'b1, 1'b0);
        value = 0;
        step(3);
        chk("seq_stage3", 32'(stage), 3);
        push(0, 1'b0, 1'b1);
        value = 2;
        step(1);
        chk("seq_done", 32'(done), 1);
        chk("seq_busy_off", 32'(busy), 0);
        step(1);

        // Stall on LT 2 with limit 5
        value = 2;
        push(1, 1'b1, 1'b0);
        go(4, 5);
        step(1);
        chk("to_stage1", 32'(stage), 1);
        chk("to_early0", 32'(timeout), 0);
        step(4);
        chk("to_early4", 32'(timeout), 0);
        chk("to_busy", 32'(busy), 1);
        step(1);
        chk("to_timeout", 32'(timeout), 1);
        chk("to_done", 32'(done), 0);
        chk("to_busy_off", 32'(busy), 0);

        // RANGE(1,3) boundaries
        cfg(0, RANGE, 1, 3);
        value = 1;
        go(1, 0);
        step(3);
        chk("rng_lo_busy", 32'(busy), 1);
        value = 3;
        step(3);
        chk("rng_hi_busy", 32'(busy), 1);
        push(0, 1'b0, 1'b1);
        value = 2;
        step(1);
        chk("rng_mid_done", 32'(done), 1);

        // Operator extremes
        for (int i = 0; i < 14; i++) begin
            cfg(0, cases[i].op, cases[i].lo, cases[i].hi);
            value = cases[i].v;
            if (cases[i].m) push(0, 1'b0, 1'b1);
            go(1, 2);
            step(2);
            chk($sformatf("op%0d_done", i), 32'(done), 32'(cases[i].m));
            chk($sformatf("op%0d_timeout", i), 32'(timeout), 32'(!cases[i].m));
        end

        // Zero stages
        value = 0;
        go(0, 0);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_stage", 32'(stage), 0);
        step(2);

        // start and cfg_we ignored while busy
        cfg(0, EQ, 5, 0);
        cfg(1, EQ, 6, 0);
        value = 0;
        go(2, 10);
        step(1);
        cfg_we = 1'b1; cfg_idx = 0; cfg_op = EQ; cfg_lo = 0;
        n_stages = 0; start = 1'b1;
        step(2);
        cfg_we = 1'b0; start = 1'b0;
        chk("ign_stage", 32'(stage), 0);
        chk("ign_busy", 32'(busy), 1);
        chk("ign_to_early", 32'(timeout), 0);
        step(6);
        chk("ign_to_e9", 32'(timeout), 0);
        step(1);
        chk("ign_to_e10", 32'(timeout), 1);

        // Asynchronous reset mid-run at stage 2
        cfg(0, EQ, 1, 0);
        cfg(1, EQ, 2, 0);
        cfg(2, EQ, 3, 0);
        value = 0;
        go(3, 0);
        push(1, 1'b1, 1'b0);
        value = 1;
        step(1);
        push(2, 1'b1, 1'b0);
        value = 2;
        step(2);
        chk("ar_stage2", 32'(stage), 2);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_stage", 32'(stage), 0);
        chk("ar_hit", 32'(hit), 0);
        chk("ar_done", 32'(done), 0);
        chk("ar_timeout", 32'(timeout), 0);
        #1 rst = 1'b0;
        step(1);
        value = 1;
        go(1, 3);
        step(2);
        chk("ar_to_early", 32'(timeout), 0);
        chk("ar_busy_run", 32'(busy), 1);
        step(1);
        chk("ar_timeout_set", 32'(timeout), 1);
        chk("ar_no_done", 32'(done), 0);

        // Match on the cycle the timer would expire
        cfg(0, EQ, 7, 0);
        value = 0;
        go(1, 4);
        step(3);
        chk("race_to_early", 32'(timeout), 0);
        push(0, 1'b0, 1'b1);
        value = 7;
        step(1);
        chk("race_done", 32'(done), 1);
        chk("race_no_to", 32'(timeout), 0);
        step(2);
        chk("race_no_to_later", 32'(timeout), 0);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL missing_hits obs_pending=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
